// File: rtl/afifo_rd_arbiter_if.sv
// afifo_rd_arbiter_if: bundle between the async FIFO read port, its consumers and the read arbiter.
//   req        per-consumer level read request
//   rempty     FIFO empty flag (read domain)
//   rdata      FIFO head word, first-word-fall-through
//   rinc       FIFO pop strobe
//   gnt        one-hot grant
//   out_valid  popped word valid pulse
//   out_data   popped word
//   out_id     consumer the popped word belongs to
//   burst_done one-cycle pulse after a grant ends
//   master = arbiter side, slave = FIFO/consumer side
interface afifo_rd_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic rinc;
  logic [NUM_REQ-1:0] gnt;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_W-1:0] out_id;
  logic burst_done;
  modport master(
    input req, rempty, rdata,
    output rinc, gnt, out_valid, out_data, out_id, burst_done
  );
  modport slave(
    output req, rempty, rdata,
    input rinc, gnt, out_valid, out_data, out_id, burst_done
  );
endinterface

// File: rtl/afifo_rd_arbiter.sv
// afifo_rd_arbiter: round-robin sharing of the async FIFO read port among NUM_REQ consumers.
//   rclk  read-domain clock
//   rrst  asynchronous active-high reset
//   bus   master side of afifo_rd_arbiter_if (req/rempty/rdata in; rinc/gnt/out_* /burst_done out)
module afifo_rd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 8
) (
  input logic rclk,
  input logic rrst,
  afifo_rd_arbiter_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [ID_W-1:0] cur, last, sel, k;
  logic [CW-1:0] cnt;
  logic found, rinc, done;
  logic [NUM_REQ-1:0] gnt;
  logic out_valid, burst_done;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_W-1:0] out_id;
  // rotating priority: first requester after the last one granted
  always_comb begin
    sel = last;
    found = 1'b0;
    k = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = ID_W'((int'(last) + i) % NUM_REQ);
      if (!found && bus.req[k]) begin
        sel = k;
        found = 1'b1;
      end
    end
  end
  assign rinc = (state == BURST) & bus.req[cur] & ~bus.rempty;
  // a burst ends on its last allowed pop or as soon as the owner drops its request
  assign done = (state == BURST) & (~bus.req[cur] | (rinc & (cnt == CW'(MAX_BURST - 1))));
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= IDLE;
      gnt <= '0;
      cur <= '0;
      last <= ID_W'(NUM_REQ - 1);
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      burst_done <= 1'b0;
    end else begin
      out_valid <= rinc;
      burst_done <= done;
      if (rinc) begin
        out_data <= bus.rdata;
        out_id <= cur;
        cnt <= cnt + CW'(1);
      end
      if (state == IDLE && found) begin
        state <= BURST;
        gnt <= NUM_REQ'(1) << sel;
        cur <= sel;
        last <= sel;
        cnt <= '0;
      end else if (done) begin
        state <= IDLE;
        gnt <= '0;
      end
    end
  end
  assign bus.rinc = rinc;
  assign bus.gnt = gnt;
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_id = out_id;
  assign bus.burst_done = burst_done;
endmodule

// File: doc/afifo_rd_arbiter.md
Name: afifo_rd_arbiter

Overview:
- Round-robin arbiter sharing the single read port of the async FIFO among NUM_REQ consumers in the read clock domain.
- Grants one consumer at a time for a burst of up to MAX_BURST words.
- Drives the FIFO pop (rinc) only when the FIFO is non-empty.
- Returns each popped word registered and tagged with the consumer ID.

Parameters:
- DATA_WIDTH, 32, FIFO word width.
- NUM_REQ, 4, number of consumers (2..16).
- MAX_BURST, 8, max words per grant (1..256).
- ID_W, $clog2(NUM_REQ), consumer ID width (derived, not overridden).

Ports:
- rclk  in  1  read-domain clock; all logic on posedge.
- rrst  in  1  reset; asynchronous, active-high.
- req  in  NUM_REQ  per-consumer read request, level.
- rempty  in  1  FIFO empty flag (rclk domain).
- rdata  in  DATA_WIDTH  FIFO head word; first-word-fall-through, valid whenever rempty=0.
- rinc  out  1  FIFO pop strobe; combinational.
- gnt  out  NUM_REQ  one-hot grant, registered.
- out_valid  out  1  registered pulse: out_data/out_id valid.
- out_data  out  DATA_WIDTH  popped word.
- out_id  out  ID_W  index of the consumer the word belongs to.
- burst_done  out  1  one-cycle pulse after a grant ends.

Behaviour:
Reset (rrst=1, any time, including mid-burst):
- gnt=0, out_valid=0, out_data=0, out_id=0, burst_done=0, rinc=0.
- State=IDLE, cnt=0, last=NUM_REQ-1, so the first search starts at consumer 0.
- A burst in progress is abandoned; no pop occurs during reset.

FSM, two states:
- IDLE:
  - gnt=0, rinc=0.
  - If req!=0, select the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - Next cycle: gnt=onehot(sel), cur=sel, last=sel, cnt=0, state=BURST.
  - The rempty value is ignored for the grant decision.
- BURST:
  - rinc = req[cur] & ~rempty.
  - On each cycle with rinc=1, next edge: out_valid=1, out_data=rdata, out_id=cur, cnt=cnt+1. Otherwise out_valid=0.
  - Exit to IDLE when (rinc & cnt==MAX_BURST-1) or req[cur]==0.
  - On exit, next edge: gnt=0, burst_done=1 (a single pulse).
  - rempty=1 with req[cur]=1: stall; hold grant, no count, no timeout.
  - req[cur] deasserted: exit that cycle with no pop; a partial burst is legal.

Timing and widths:
- Pop-to-data latency is 1 cycle: the word popped at edge N appears on out_data after edge N.
- Minimum gap between bursts is one IDLE cycle.
- Arbitration latency is 1 cycle from req to gnt.
- cnt width is $clog2(MAX_BURST+1); it never wraps, because exit occurs at MAX_BURST.
- last updates only on grant.
- A requester with req held continuously rejoins the rotation after all other active requesters have been served.

Invariants (bench asserts):
- rinc never 1 while rempty=1.
- rinc only in BURST.
- gnt is one-hot or zero.
- Words per grant ≤ MAX_BURST.
- out_valid count equals rinc count.

Test Plan:
- Reset, then req=4'b0001 with 3 words queued (D0..D2), MAX_BURST=8 → gnt=0001 one cycle after req. rinc high 3 cycles. out_data D0,D1,D2 with out_id=0. The FIFO then empties while req stays high: stall, grant held, no further pops.
- req=4'b1111 held, FIFO non-empty with 40 words → grants in order 0,1,2,3,0. Each burst is exactly 8 pops. burst_done pulses after each burst. One idle cycle between bursts.
- During consumer 2's burst, FIFO goes empty after 3 pops, refills 5 cycles later → rinc=0 and cnt frozen while empty. Burst resumes and completes 8 words total. rinc is never asserted with rempty=1.
- Consumer 1 drops req after 2 pops, req=4'b0110 → burst ends with 2 words. burst_done pulses. Next gnt=0100 (consumer 2), not consumer 1.
- rrst asserted mid-burst at cnt=4 → outputs zero immediately (asynchronous). After release with req=4'b1000, the search starts from 0 and grants consumer 3. No pop occurs during reset.
- MAX_BURST=1, req=4'b0101 → alternating grants 0,2,0,2, one word each, out_id alternating 0/2.
